// File: rtl/cpu_trace_emitter.sv
// Serialises register/memory write trace records into an ASCII character stream.
// Optional feature: define TRACE_LEADING_ZERO_EN for fixed 4-digit TIME and REG fields.
module cpu_trace_emitter (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_kind,
  input  logic [13:0] in_time,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_id,
  input  logic [31:0] in_data,
  output logic [7:0]  out_char,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        done
);

`ifdef TRACE_LEADING_ZERO_EN
  localparam logic LEAD_ZERO = 1'b1;
`else
  localparam logic LEAD_ZERO = 1'b0;
`endif

  typedef enum logic [3:0] {
    IDLE,
    CARET,
    TIME,
    AT,
    PC,
    COLON,
    SP1,
    SIGIL,
    ID,
    SP2,
    LT,
    EQ,
    SP3,
    DATA,
    HASH
  } state_t;

  state_t state_q;
  state_t state_d;
  logic [2:0] cnt_q;
  logic [2:0] cnt_d;

  logic        kind_q;
  logic [15:0] time_bcd_q;
  logic [1:0]  time_top_q;
  logic [31:0] pc_q;
  logic [31:0] id_q;
  logic [15:0] reg_bcd_q;
  logic [1:0]  reg_top_q;
  logic [31:0] data_q;
  logic        done_q;

  logic        accept;
  logic        xfer;
  logic [15:0] time_bcd_w;
  logic [15:0] reg_bcd_w;
  logic [1:0]  time_top_w;
  logic [1:0]  reg_top_w;

  // Saturating double-dabble: values above 9999 clamp before conversion.
  function automatic logic [15:0] to_bcd(
    input logic [13:0] v
  );
    logic [13:0] s;
    logic [29:0] sh;
    s  = (v > 14'd9999) ? 14'd9999 : v;
    sh = {16'd0, s};
    for (int i = 0; i < 14; i++) begin
      for (int d = 0; d < 4; d++) begin
        if (sh[14+4*d +: 4] >= 4'd5) begin
          sh[14+4*d +: 4] = sh[14+4*d +: 4] + 4'd3;
        end
      end
      sh = sh << 1;
    end
    return sh[29:14];
  endfunction

  function automatic logic [1:0] top_of(
    input logic [15:0] b
  );
    logic [1:0] t;
    if (b[15:12] != 4'd0)     t = 2'd3;
    else if (b[11:8] != 4'd0) t = 2'd2;
    else if (b[7:4] != 4'd0)  t = 2'd1;
    else                      t = 2'd0;
    return t;
  endfunction

  function automatic logic [7:0] dec_char(
    input logic [15:0] b,
    input logic [1:0]  idx
  );
    return {4'h3, b[idx*4 +: 4]};
  endfunction

  function automatic logic [7:0] hex_char(
    input logic [31:0] w,
    input logic [2:0]  idx
  );
    logic [3:0] n;
    n = w[idx*4 +: 4];
    if (n < 4'd10) return {4'h3, n};
    return 8'h57 + {4'h0, n};
  endfunction

  assign in_ready   = (state_q == IDLE) && !reset;
  assign accept     = in_valid && in_ready;
  assign done       = done_q && !reset;
  assign time_bcd_w = to_bcd(in_time);
  assign reg_bcd_w  = to_bcd(in_id[13:0]);
  assign time_top_w = LEAD_ZERO ? 2'd3 : top_of(time_bcd_w);
  assign reg_top_w  = LEAD_ZERO ? 2'd3 : top_of(reg_bcd_w);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= (state_q == HASH) && xfer;
    end
  end

  // Decimal digits are converted at acceptance so the
  // first character needs no extra cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      kind_q     <= 1'b0;
      time_bcd_q <= 16'd0;
      time_top_q <= 2'd0;
      pc_q       <= 32'd0;
      id_q       <= 32'd0;
      reg_bcd_q  <= 16'd0;
      reg_top_q  <= 2'd0;
      data_q     <= 32'd0;
    end else if (accept) begin
      kind_q     <= in_kind;
      time_bcd_q <= time_bcd_w;
      time_top_q <= time_top_w;
      pc_q       <= in_pc;
      id_q       <= in_id;
      reg_bcd_q  <= reg_bcd_w;
      reg_top_q  <= reg_top_w;
      data_q     <= in_data;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    out_valid = (state_q != IDLE) && !reset;
    out_char  = 8'h00;
    xfer      = out_valid && out_ready;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = CARET;
      end
      CARET: begin
        out_char = "^";
        if (xfer) begin
          state_d = TIME;
          cnt_d   = {1'b0, time_top_q};
        end
      end
      TIME: begin
        out_char = dec_char(time_bcd_q, cnt_q[1:0]);
        if (xfer) begin
          if (cnt_q == 3'd0) state_d = AT;
          else               cnt_d = cnt_q - 3'd1;
        end
      end
      AT: begin
        out_char = "@";
        if (xfer) begin
          state_d = PC;
          cnt_d   = 3'd7;
        end
      end
      PC: begin
        out_char = hex_char(pc_q, cnt_q);
        if (xfer) begin
          if (cnt_q == 3'd0) state_d = COLON;
          else               cnt_d = cnt_q - 3'd1;
        end
      end
      COLON: begin
        out_char = ":";
        if (xfer) state_d = SP1;
      end
      SP1: begin
        out_char = " ";
        if (xfer) state_d = SIGIL;
      end
      SIGIL: begin
        out_char = kind_q ? "*" : "$";
        if (xfer) begin
          state_d = ID;
          cnt_d   = kind_q ? 3'd7 : {1'b0, reg_top_q};
        end
      end
      ID: begin
        if (kind_q) out_char = hex_char(id_q, cnt_q);
        else        out_char = dec_char(reg_bcd_q, cnt_q[1:0]);
        if (xfer) begin
          if (cnt_q == 3'd0) state_d = SP2;
          else               cnt_d = cnt_q - 3'd1;
        end
      end
      SP2: begin
        out_char = " ";
        if (xfer) state_d = LT;
      end
      LT: begin
        out_char = "<";
        if (xfer) state_d = EQ;
      end
      EQ: begin
        out_char = "=";
        if (xfer) state_d = SP3;
      end
      SP3: begin
        out_char = " ";
        if (xfer) begin
          state_d = DATA;
          cnt_d   = 3'd7;
        end
      end
      DATA: begin
        out_char = hex_char(data_q, cnt_q);
        if (xfer) begin
          if (cnt_q == 3'd0) state_d = HASH;
          else               cnt_d = cnt_q - 3'd1;
        end
      end
      HASH: begin
        out_char = "#";
        if (xfer) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (!out_valid) out_char = 8'h00;
  end

endmodule

// File: doc/cpu_trace_emitter.md
CPU_TRACE_EMITTER -- requirements
Module: cpu_trace_emitter

Interface
REQ-001 SHALL have: clk  input  1  rising-edge clock.
REQ-002 SHALL have: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have: in_valid  input  1  trace record offered.
REQ-004 SHALL have: in_ready  output  1  emitter idle; record accepted when in_valid && in_ready.
REQ-005 SHALL have: in_kind  input  1  0 = register write, 1 = memory write.
REQ-006 SHALL have: in_time  input  14  cycle stamp, decimal field.
REQ-007 SHALL have: in_pc  input  32  PC, hex field.
REQ-008 SHALL have: in_id  input  32  kind 0: register number in bits [13:0], decimal; kind 1: address, hex.
REQ-009 SHALL have: in_data  input  32  written value, hex field.
REQ-010 SHALL have: out_char  output  8  ASCII character.
REQ-011 SHALL have: out_valid  output  1  out_char valid.
REQ-012 SHALL have: out_ready  input  1  sink accepts; a char transfers when out_valid && out_ready.
REQ-013 SHALL have: done  output  1  one-cycle pulse after the final character transfers.

Function
REQ-014 SHALL latch all in_* fields on acceptance; later input changes SHALL NOT affect the record in flight.
REQ-015 SHALL drive in_ready=1 only in IDLE with reset low.
REQ-016 SHALL emit, kind 0: "^" TIME "@" PC ": $" REG " <= " DATA "#".
REQ-017 SHALL emit, kind 1: "^" TIME "@" PC ": *" ADDR " <= " DATA "#".
REQ-018 PC, ADDR, DATA SHALL be exactly 8 lowercase hex digits (0-9, a-f), MSB nibble first, zero-padded.
REQ-019 TIME and REG SHALL be decimal, 1-4 digits, no leading zeros, and a single "0" for value 0; values above 9999 SHALL saturate to 9999.
REQ-020 The first character SHALL present out_valid=1 in the cycle after acceptance.
REQ-021 One character SHALL transfer per cycle while out_ready=1, with no bubbles.
REQ-022 While out_valid=1 and out_ready=0, out_char SHALL hold stable and the FSM SHALL NOT advance.
REQ-023 FSM states SHALL be: IDLE, CARET, TIME, AT, PC, COLON, SP1, SIGIL, ID, SP2, LT, EQ, SP3, DATA, HASH.
REQ-024 Each state SHALL advance on a transfer; TIME, ID, and DATA SHALL advance after their last digit transfers.
REQ-025 Decimal digits SHALL come from a fixed BCD conversion of the latched value, completed before the digit is presented; this conversion SHALL NOT add latency beyond REQ-020.
REQ-026 On the '#' transfer, the FSM SHALL enter IDLE; the next cycle SHALL have done=1, out_valid=0, and in_ready=1.
REQ-027 A new record SHALL be accepted no earlier than the done cycle.
REQ-028 out_char SHALL be 8'h00 whenever out_valid=0.

Reset
REQ-029 Reset SHALL force: IDLE; out_valid=0; out_char=0; done=0; in_ready=0 during the reset cycle and 1 afterwards.
REQ-030 Reset SHALL clear all digit counters and latched fields.
REQ-031 Reset mid-record SHALL abandon the record: no further characters and no done pulse.
REQ-032 Reset SHALL take priority over in_valid and out_ready.

Configuration
REQ-033 With TRACE_LEADING_ZERO_EN defined, TIME and REG SHALL always be emitted as exactly 4 zero-padded digits (e.g. "0005").
REQ-034 Without TRACE_LEADING_ZERO_EN, TIME and REG SHALL follow REQ-019.
REQ-035 All other behaviour SHALL be identical with and without TRACE_LEADING_ZERO_EN.

Verification
REQ-036 Register record: kind=0, time=5, pc=0x00003000, id=2, data=0x1234abcd, out_ready=1 -> "^5@00003000: $2 <= 1234abcd#" (28 chars, consecutive cycles), then a done pulse.
REQ-037 Memory record: kind=1, time=1234, pc=0x0000300c, id=0x00000010, data=0xffffffff -> "^1234@0000300c: *00000010 <= ffffffff#" (38 chars).
REQ-038 Backpressure: out_ready toggles 1,0,0,1,... during a record -> identical string; out_char constant while stalled; in_ready=0 until done.
REQ-039 Boundaries: time=0 -> "^0@..."; time=12000 -> "^9999@..."; reg=0 -> "$0".
REQ-040 Reset while the 10th character is presented -> out_valid=0 next cycle, no done pulse, in_ready=1 the following cycle; the next record emits correctly.
REQ-041 TRACE_LEADING_ZERO_EN build, REQ-036 stimulus -> "^0005@00003000: $0002 <= 1234abcd#".
